// File: rtl/alu_cmd_sequencer_if.sv
// Command, response and ALU-side signals of the ALU command sequencer.
// slave: sequencer view. master: front end / ALU / consumer view.
interface alu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_imm;
  logic        cmd_wb;

  logic [3:0]  alu_opcode;
  logic [7:0]  alu_operand1;
  logic [7:0]  alu_operand2;
  logic [15:0] alu_result;
  logic        alu_flagC;
  logic        alu_flagZ;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_flagC;
  logic        rsp_flagZ;
  logic        rsp_err;

  logic [7:0]  acc;

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_imm,
    input  cmd_wb,
    output cmd_ready,
    output alu_opcode,
    output alu_operand1,
    output alu_operand2,
    input  alu_result,
    input  alu_flagC,
    input  alu_flagZ,
    output rsp_valid,
    input  rsp_ready,
    output rsp_result,
    output rsp_flagC,
    output rsp_flagZ,
    output rsp_err,
    output acc
  );

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_imm,
    output cmd_wb,
    input  cmd_ready,
    input  alu_opcode,
    input  alu_operand1,
    input  alu_operand2,
    output alu_result,
    output alu_flagC,
    output alu_flagZ,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_result,
    input  rsp_flagC,
    input  rsp_flagZ,
    input  rsp_err,
    input  acc
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the 8-bit combinational ALU: one command in flight,
// accumulator + carry/zero registers, valid/ready command and response.
// Ports: clk, rst_n (async, active low), sq (alu_cmd_sequencer_if.slave):
//   cmd_valid/ready/op/imm/wb in, alu_opcode/operand1/operand2 out,
//   alu_result/flagC/flagZ in, rsp_valid/ready/result/flagC/flagZ/err,
//   acc out.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  ACC_RESET     = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.slave   sq
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_LOCAL,
    S_RESP
  } state_e;

  state_e      state_q;
  logic [3:0]  op_q;
  logic [7:0]  imm_q;
  logic        wb_q;
  logic [3:0]  cnt_q;

  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_result_q;
  logic        rsp_err_q;

  logic [3:0]  alu_opcode_q;
  logic [7:0]  alu_op1_q;
  logic [7:0]  alu_op2_q;

  logic [7:0]  acc_q;
  logic        carry_q;
  logic        zero_q;

  logic        accept;
  logic        cmd_is_alu;
  logic        op_sets_carry;
  logic        op_is_ldi;

  assign accept        = sq.cmd_valid & cmd_ready_q;
  assign cmd_is_alu    = (sq.cmd_op <= 4'hB);
  assign op_sets_carry = (op_q <= 4'h5);
  assign op_is_ldi     = (op_q == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= 4'h0;
      imm_q        <= 8'h00;
      wb_q         <= 1'b0;
      cnt_q        <= 4'h0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 16'h0000;
      rsp_err_q    <= 1'b0;
      alu_opcode_q <= 4'h0;
      alu_op1_q    <= 8'h00;
      alu_op2_q    <= 8'h00;
      acc_q        <= ACC_RESET;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q        <= sq.cmd_op;
            imm_q       <= sq.cmd_imm;
            wb_q        <= sq.cmd_wb;
            cmd_ready_q <= 1'b0;
            if (cmd_is_alu) begin
              // Operands freeze here and stay put until
              // the next ALU-op accept.
              alu_opcode_q <= sq.cmd_op;
              alu_op1_q    <= acc_q;
              alu_op2_q    <= sq.cmd_imm;
              cnt_q        <= CNT_INIT;
              state_q      <= S_ISSUE;
            end else begin
              state_q <= S_LOCAL;
            end
          end
        end

        S_ISSUE: begin
          if (cnt_q == 4'h0) begin
            rsp_result_q <= sq.alu_result;
            rsp_err_q    <= 1'b0;
            // Z follows the full 16-bit result,
            // not the written-back byte.
            zero_q       <= sq.alu_flagZ;
            if (op_sets_carry) begin
              carry_q <= sq.alu_flagC;
            end
            if (wb_q) begin
              acc_q <= sq.alu_result[7:0];
            end
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'h1;
          end
        end

        S_LOCAL: begin
          // ldi and illegal ops never touch the ALU.
          if (op_is_ldi) begin
            rsp_result_q <= {8'h00, imm_q};
            rsp_err_q    <= 1'b0;
            acc_q        <= imm_q;
            zero_q       <= (imm_q == 8'h00);
          end else begin
            rsp_result_q <= 16'h0000;
            rsp_err_q    <= 1'b1;
          end
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end

        S_RESP: begin
          if (sq.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign sq.cmd_ready    = cmd_ready_q;
  assign sq.alu_opcode   = alu_opcode_q;
  assign sq.alu_operand1 = alu_op1_q;
  assign sq.alu_operand2 = alu_op2_q;
  assign sq.rsp_valid    = rsp_valid_q;
  assign sq.rsp_result   = rsp_result_q;
  assign sq.rsp_flagC    = carry_q;
  assign sq.rsp_flagZ    = zero_q;
  assign sq.rsp_err      = rsp_err_q;
  assign sq.acc          = acc_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: two instances (settle 1 and 4),
// directed scenarios plus random commands against a reference model.
module tb_alu_cmd_sequencer;

  localparam int unsigned S0 = 1;
  localparam int unsigned S1 = 4;
  localparam logic [7:0]  R0 = 8'h00;
  localparam logic [7:0]  R1 = 8'h5A;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if i0 ();
  alu_cmd_sequencer_if i1 ();

  alu_cmd_sequencer #(.SETTLE_CYCLES(S0), .ACC_RESET(R0)) u0 (
    .clk(clk), .rst_n(rst_n), .sq(i0.slave)
  );
  alu_cmd_sequencer #(.SETTLE_CYCLES(S1), .ACC_RESET(R1)) u1 (
    .clk(clk), .rst_n(rst_n), .sq(i1.slave)
  );

  // Behavioural ALU: returns {C, Z, result}.
  function automatic logic [17:0] alu_fn(
    logic [3:0] op, logic [7:0] a, logic [7:0] b
  );
    logic [15:0] r;
    logic        c;
    r = 16'h0;
    c = 1'b0;
    case (op)
      4'h0, 4'h1: begin r = 16'(a) + 16'(b); c = r[8]; end
      4'h2, 4'h3: begin r = 16'(a) - 16'(b); c = (a < b); end
      4'h4: begin r = 16'(a) + 16'd1; c = r[8]; end
      4'h5: begin r = 16'(a) - 16'd1; c = (a == 8'h00); end
      4'h6: r = {8'h00, a & b};
      4'h7: r = {8'h00, a | b};
      4'h8: r = {8'h00, a ^ b};
      4'h9: r = {8'h00, ~a};
      4'hA: begin r = 16'(a) << 1; c = a[7]; end
      4'hB: begin r = {8'h00, a >> 1}; c = a[0]; end
      default: r = 16'h0;
    endcase
    return {c, (r == 16'h0), r};
  endfunction

  assign {i0.alu_flagC, i0.alu_flagZ, i0.alu_result} =
    alu_fn(i0.alu_opcode, i0.alu_operand1, i0.alu_operand2);
  assign {i1.alu_flagC, i1.alu_flagZ, i1.alu_result} =
    alu_fn(i1.alu_opcode, i1.alu_operand1, i1.alu_operand2);

  logic       cv  [2];
  logic [3:0] cop [2];
  logic [7:0] cim [2];
  logic       cwb [2];
  logic       rr  [2];

  assign i0.cmd_valid = cv[0];
  assign i0.cmd_op    = cop[0];
  assign i0.cmd_imm   = cim[0];
  assign i0.cmd_wb    = cwb[0];
  assign i0.rsp_ready = rr[0];
  assign i1.cmd_valid = cv[1];
  assign i1.cmd_op    = cop[1];
  assign i1.cmd_imm   = cim[1];
  assign i1.cmd_wb    = cwb[1];
  assign i1.rsp_ready = rr[1];

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        err;
    logic [7:0]  acc;
    logic [3:0]  aop;
    logic [7:0]  a1;
    logic [7:0]  a2;
  } obs_t;

  obs_t ob [2];
  assign ob[0] = '{i0.cmd_ready, i0.rsp_valid, i0.rsp_result,
                   i0.rsp_flagC, i0.rsp_flagZ, i0.rsp_err, i0.acc,
                   i0.alu_opcode, i0.alu_operand1, i0.alu_operand2};
  assign ob[1] = '{i1.cmd_ready, i1.rsp_valid, i1.rsp_result,
                   i1.rsp_flagC, i1.rsp_flagZ, i1.rsp_err, i1.acc,
                   i1.alu_opcode, i1.alu_operand1, i1.alu_operand2};

  // Reference model state.
  logic [7:0] m_acc [2];
  logic       m_c   [2];
  logic       m_z   [2];
  logic [3:0] m_aop [2];
  logic [7:0] m_a1  [2];
  logic [7:0] m_a2  [2];

  int total = 0;
  int bad   = 0;

  function automatic int sc_of(int w);
    return (w == 0) ? int'(S0) : int'(S1);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_acc[w] = (w == 0) ? R0 : R1;
      m_c[w]   = 1'b0;
      m_z[w]   = 1'b0;
      m_aop[w] = 4'h0;
      m_a1[w]  = 8'h00;
      m_a2[w]  = 8'h00;
    end
  endtask

  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic do_cmd(int w, logic [3:0] op, logic [7:0] imm,
                        logic wb, int hold, string tag);
    int          k;
    int          lat;
    logic [17:0] f;
    logic [15:0] e_res;
    logic        e_err;
    obs_t        s;
    chk($sformatf("%s/idle_rdy", tag), 64'(ob[w].rdy), 64'd1);
    cv[w] = 1'b1; cop[w] = op; cim[w] = imm; cwb[w] = wb;
    @(posedge clk);
    @(negedge clk);
    cv[w] = 1'b0;
    cop[w] = 4'($urandom);
    cim[w] = 8'($urandom);
    cwb[w] = 1'($urandom);
    chk($sformatf("%s/busy_rdy", tag), 64'(ob[w].rdy), 64'd0);
    e_err = 1'b0;
    if (op <= 4'hB) begin
      f = alu_fn(op, m_acc[w], imm);
      e_res = f[15:0];
      m_aop[w] = op;
      m_a1[w]  = m_acc[w];
      m_a2[w]  = imm;
      if (wb) m_acc[w] = f[7:0];
      m_z[w] = f[16];
      if (op <= 4'h5) m_c[w] = f[17];
      lat = sc_of(w);
    end else if (op == 4'hF) begin
      e_res = {8'h00, imm};
      m_acc[w] = imm;
      m_z[w] = (imm == 8'h00);
      lat = 1;
    end else begin
      e_res = 16'h0000;
      e_err = 1'b1;
      lat = 1;
    end
    k = 0;
    while (!ob[w].vld && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s/latency", tag), 64'(k), 64'(lat));
    chk($sformatf("%s/result", tag), 64'(ob[w].res), 64'(e_res));
    chk($sformatf("%s/err", tag), 64'(ob[w].err), 64'(e_err));
    chk($sformatf("%s/flags", tag), 64'({ob[w].c, ob[w].z}),
        64'({m_c[w], m_z[w]}));
    chk($sformatf("%s/acc", tag), 64'(ob[w].acc), 64'(m_acc[w]));
    chk($sformatf("%s/alu_in", tag),
        64'({ob[w].aop, ob[w].a1, ob[w].a2}),
        64'({m_aop[w], m_a1[w], m_a2[w]}));
    chk($sformatf("%s/resp_rdy", tag), 64'(ob[w].rdy), 64'd0);
    s = ob[w];
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        cv[w] = 1'b1; cop[w] = 4'hF; cim[w] = 8'hC3; cwb[w] = 1'b1;
      end
      @(negedge clk);
      cv[w] = 1'b0;
      chk($sformatf("%s/hold%0d", tag, h), 64'(ob[w]), 64'(s));
    end
    rr[w] = 1'b1;
    @(negedge clk);
    rr[w] = 1'b0;
    chk($sformatf("%s/done", tag), 64'({ob[w].vld, ob[w].rdy}), 64'b01);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 2; w++) begin
      cv[w] = 1'b0; cop[w] = 4'h0; cim[w] = 8'h00;
      cwb[w] = 1'b0; rr[w] = 1'b0;
    end
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk($sformatf("rst%0d/acc", w), 64'(ob[w].acc), 64'(m_acc[w]));
      chk($sformatf("rst%0d/vld", w), 64'(ob[w].vld), 64'd0);
      chk($sformatf("rst%0d/alu", w),
          64'({ob[w].aop, ob[w].a1, ob[w].a2}), 64'd0);
      chk($sformatf("rst%0d/rsp", w),
          64'({ob[w].res, ob[w].c, ob[w].z, ob[w].err}), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int w = 0; w < 2; w++)
      chk($sformatf("rel%0d/rdy", w), 64'(ob[w].rdy), 64'd1);

    // Carry out of bit 7, wide result, zero flag, carry hold
    do_cmd(0, 4'hF, 8'h7F, 1'b0, 0, "ldi7f");
    do_cmd(0, 4'h1, 8'h01, 1'b1, 0, "addc80");
    chk("t2/acc80", 64'(ob[0].acc), 64'h80);
    do_cmd(0, 4'hF, 8'hFF, 1'b0, 0, "ldiff");
    do_cmd(0, 4'h1, 8'h01, 1'b1, 1, "addc100");
    chk("t3/cz", 64'({ob[0].c, ob[0].z, ob[0].acc}), 64'({2'b10, 8'h00}));
    do_cmd(0, 4'h6, 8'h00, 1'b1, 0, "and00");
    chk("t3b/cz", 64'({ob[0].c, ob[0].z}), 64'b11);

    // Decrement wrap on both settle settings
    do_cmd(0, 4'hF, 8'h00, 1'b0, 0, "ldi00");
    do_cmd(0, 4'h5, 8'h00, 1'b1, 0, "dec");
    chk("t4/acc", 64'(ob[0].acc), 64'hFF);
    do_cmd(1, 4'hF, 8'h00, 1'b0, 0, "s4_ldi00");
    do_cmd(1, 4'h5, 8'h00, 1'b1, 2, "s4_dec");

    // Back-pressure with ignored command, then illegal opcode
    do_cmd(0, 4'hF, 8'h33, 1'b0, 5, "ldi_hold");
    do_cmd(0, 4'hC, 8'h12, 1'b1, 5, "illegal_c");
    do_cmd(1, 4'hE, 8'h99, 1'b1, 1, "illegal_e");

    // Random commands
    for (int n = 0; n < 60; n++) begin
      do_cmd(n % 2, 4'($urandom_range(0, 15)), 8'($urandom),
             1'($urandom), $urandom_range(0, 3), $sformatf("rnd%0d", n));
    end

    // Reset while an ALU op is settling
    do_cmd(1, 4'hF, 8'h10, 1'b0, 0, "pre_rst");
    cv[1] = 1'b1; cop[1] = 4'h0; cim[1] = 8'h05; cwb[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cv[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst/vld", 64'(ob[1].vld), 64'd0);
    chk("midrst/acc", 64'(ob[1].acc), 64'(R1));
    chk("midrst/rdy", 64'(ob[1].rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst/novld", 64'(ob[1].vld), 64'd0);
    do_cmd(1, 4'h4, 8'h00, 1'b1, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
